// File: rtl/core_task_receiver.sv
// Core-side dispatch endpoint: takes a header plus instruction frames from the scheduler,
// serialises them into instruction memory and launches the core. Optional: CORE_RX_PROTO_CHECK_EN.
module core_task_receiver #(
  parameter int TM_WIDTH     = 128,
  parameter int INSN_WIDTH   = 16,
  parameter int IF_NUM_WIDTH = 4,
  parameter int REG_WIDTH    = 8,
  parameter int IMEM_AW      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TM_WIDTH-1:0]   insn_data,
  input  logic                  init_r0_vect,
  input  logic [REG_WIDTH-1:0]  init_r0,
  output logic                  ready,
  output logic                  imem_we,
  output logic [IMEM_AW-1:0]    imem_addr,
  output logic [INSN_WIDTH-1:0] imem_wdata,
  output logic                  core_r0_we,
  output logic [REG_WIDTH-1:0]  core_r0_data,
  output logic                  core_run,
  input  logic                  core_done,
  output logic                  proto_err
);

  localparam int FRAME_INSNS = TM_WIDTH / INSN_WIDTH;
  localparam int SLOT_W      = (FRAME_INSNS > 1) ? $clog2(FRAME_INSNS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, LOAD, RUN} state_e;

  state_e                  state_q, state_d;
  logic [IF_NUM_WIDTH-1:0] frames_left_q, frames_left_d;
  logic [IMEM_AW-1:0]      base_q, base_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [TM_WIDTH-1:0]     frame_q, frame_d;
  logic                    r0_we_q, r0_we_d;
  logic [REG_WIDTH-1:0]    r0_data_q, r0_data_d;
  logic                    run_q, run_d;
  logic [IF_NUM_WIDTH-1:0] hdr_n;

  assign hdr_n = insn_data[IF_NUM_WIDTH-1:0];

  // The frame buffer shifts down one slot per write, so the write data is always its low slice.
  assign ready        = (state_q == IDLE) || (state_q == WAIT_FRAME);
  assign imem_we      = (state_q == LOAD);
  assign imem_addr    = base_q + IMEM_AW'(slot_q);
  assign imem_wdata   = frame_q[INSN_WIDTH-1:0];
  assign core_r0_we   = r0_we_q;
  assign core_r0_data = r0_data_q;
  assign core_run     = run_q;

  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    base_d        = base_q;
    slot_d        = slot_q;
    frame_d       = frame_q;
    r0_we_d       = 1'b0;
    r0_data_d     = r0_data_q;
    run_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          frames_left_d = hdr_n;
          base_d        = '0;
          slot_d        = '0;
          if (init_r0_vect) begin
            r0_we_d   = 1'b1;
            r0_data_d = init_r0;
          end
          if (hdr_n == '0) begin
            state_d = RUN;
            run_d   = 1'b1;
          end else begin
            state_d = WAIT_FRAME;
          end
        end
      end
      WAIT_FRAME: begin
        if (start) begin
          frame_d = insn_data;
          slot_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        frame_d = frame_q >> INSN_WIDTH;
        slot_d  = slot_q + SLOT_W'(1);
        if (slot_q == SLOT_W'(FRAME_INSNS - 1)) begin
          slot_d        = '0;
          base_d        = base_q + IMEM_AW'(FRAME_INSNS);
          frames_left_d = frames_left_q - IF_NUM_WIDTH'(1);
          if (frames_left_q == IF_NUM_WIDTH'(1)) begin
            state_d = RUN;
            run_d   = 1'b1;
          end else begin
            state_d = WAIT_FRAME;
          end
        end
      end
      RUN: begin
        if (core_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      frames_left_q <= '0;
      base_q        <= '0;
      slot_q        <= '0;
      frame_q       <= '0;
      r0_we_q       <= 1'b0;
      r0_data_q     <= '0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      frames_left_q <= frames_left_d;
      base_q        <= base_d;
      slot_q        <= slot_d;
      frame_q       <= frame_d;
      r0_we_q       <= r0_we_d;
      r0_data_q     <= r0_data_d;
      run_q         <= run_d;
    end
  end

`ifdef CORE_RX_PROTO_CHECK_EN
  localparam int          IMEM_DEPTH = 2 ** IMEM_AW;
  localparam int unsigned MAX_FRAMES = IMEM_DEPTH / FRAME_INSNS;

  logic proto_err_q, proto_err_d;

  // Sticky: a stray start while busy, or a header that would overrun the memory.
  always_comb begin
    proto_err_d = proto_err_q;
    if (start && ((state_q == LOAD) || (state_q == RUN))) proto_err_d = 1'b1;
    if (start && (state_q == IDLE) && (32'(hdr_n) > MAX_FRAMES)) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) proto_err_q <= 1'b0;
    else       proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule
